// File: rtl/clk_pkg.sv
// clk_pkg: shared clocking-peripheral types for the PLL reset sequencer.
// Holds the sequencer state encoding and counter-width helpers.
package clk_pkg;
  localparam int STATE_W = $clog2(5);
  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;
  typedef enum logic [STATE_W-1:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_QUALIFY,
    S_RUN,
    S_FAULT
  } seq_state_e;
  // Counters of depth 1 still need one bit of storage.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous status bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end
  assign o_q = r_sync;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, qualifies lock, and releases the
// downstream reset; retries on lock timeout and parks in a sticky FAULT.
module pll_reset_sequencer
  import clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               force_relock,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [LOSS_W-1:0]  loss_count
);
  localparam int TW = cnt_w(LOCK_TIMEOUT > PLL_RST_CYCLES ? LOCK_TIMEOUT : PLL_RST_CYCLES);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam logic [TW-1:0]      RST_LAST  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0]      TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0]      STB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic               w_locked_s;
  seq_state_e         r_state, w_state_nx;
  logic [TW-1:0]      r_timer, w_timer_nx;
  logic [SW-1:0]      r_stable, w_stable_nx;
  logic [RETRY_W-1:0] r_retry, w_retry_nx, w_retry_inc;
  logic [LOSS_W-1:0]  r_loss, w_loss_nx;
  logic               r_pll_rst, r_sys_rst_n, r_ready, r_fault;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  assign w_retry_inc = r_retry + RETRY_W'(1);

  always_comb begin
    w_state_nx  = r_state;
    w_timer_nx  = r_timer;
    w_stable_nx = r_stable;
    w_retry_nx  = r_retry;
    w_loss_nx   = r_loss;
    case (r_state)
      S_RESET_PLL: begin
        w_state_nx = (r_timer == RST_LAST) ? S_WAIT_LOCK : S_RESET_PLL;
        w_timer_nx = (r_timer == RST_LAST) ? '0 : r_timer + TW'(1);
      end
      S_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nx  = S_QUALIFY;
          w_stable_nx = '0;
          w_timer_nx  = '0;
        end else if (r_timer == TO_LAST) begin
          w_retry_nx = w_retry_inc;
          w_state_nx = (w_retry_inc == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
          w_timer_nx = '0;
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      S_QUALIFY: begin
        if (!w_locked_s) begin
          w_state_nx = S_WAIT_LOCK;
          w_timer_nx = '0;
        end else if (r_stable == STB_LAST) begin
          w_state_nx  = S_RUN;
          w_retry_nx  = '0;
          w_stable_nx = '0;
        end else begin
          w_stable_nx = r_stable + SW'(1);
        end
      end
      S_RUN: begin
        // A simultaneous loss and force_relock is one relock, counted once.
        if (!w_locked_s || force_relock) begin
          w_state_nx = S_RESET_PLL;
          w_timer_nx = '0;
        end
        if (!w_locked_s && r_loss != '1) w_loss_nx = r_loss + LOSS_W'(1);
      end
      S_FAULT: begin
        if (force_relock) begin
          w_state_nx = S_RESET_PLL;
          w_retry_nx = '0;
          w_timer_nx = '0;
        end
      end
      default: begin
        w_state_nx = S_RESET_PLL;
        w_timer_nx = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RESET_PLL;
      r_timer     <= '0;
      r_stable    <= '0;
      r_retry     <= '0;
      r_loss      <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_timer     <= w_timer_nx;
      r_stable    <= w_stable_nx;
      r_retry     <= w_retry_nx;
      r_loss      <= w_loss_nx;
      r_pll_rst   <= (w_state_nx == S_RESET_PLL);
      r_sys_rst_n <= (w_state_nx == S_RUN);
      r_ready     <= (w_state_nx == S_RUN);
      r_fault     <= (w_state_nx == S_FAULT);
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst_n   = r_sys_rst_n;
  assign ready       = r_ready;
  assign fault       = r_fault;
  assign retry_count = r_retry;
  assign loss_count  = r_loss;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed bench for pll_reset_sequencer with
// PLL_RST_CYCLES=3, LOCK_TIMEOUT=16, STABLE_CYCLES=4, MAX_RETRIES=2.
module tb_pll_reset_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b1;
  logic       force_relock = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault;
  logic [3:0] retry_count;
  logic [7:0] loss_count;
  int         passed = 0;
  int         failed = 0;
  int         total = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (3),
    .LOCK_TIMEOUT   (16),
    .STABLE_CYCLES  (4),
    .MAX_RETRIES    (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fault        (fault),
    .retry_count  (retry_count),
    .loss_count   (loss_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    for (int i = 0; i < budget && ready !== 1'b1; i++) tick();
    chk(tag, 32'(ready), 1);
  endtask

  initial begin
    tick(3);
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_sys_rst_n", 32'(sys_rst_n), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_retry", 32'(retry_count), 0);
    chk("rst_loss", 32'(loss_count), 0);
    // Bring-up with lock already present.
    rst_n = 1'b1;
    tick(2);
    chk("up_pulse_e2", 32'(pll_rst), 1);
    tick();
    chk("up_pulse_end", 32'(pll_rst), 0);
    tick(4);
    chk("up_ready_e7", 32'(ready), 0);
    tick();
    chk("up_ready_e8", 32'(ready), 1);
    chk("up_sys_rst_n", 32'(sys_rst_n), 1);
    chk("up_retry", 32'(retry_count), 0);
    // Lock loss in RUN.
    pll_locked = 1'b0;
    tick(2);
    chk("loss_sys_e2", 32'(sys_rst_n), 1);
    tick();
    chk("loss_sys_e3", 32'(sys_rst_n), 0);
    chk("loss_ready", 32'(ready), 0);
    chk("loss_count1", 32'(loss_count), 1);
    chk("loss_pll_rst", 32'(pll_rst), 1);
    pll_locked = 1'b1;
    tick(2);
    chk("loss_pulse_e3", 32'(pll_rst), 1);
    tick();
    chk("loss_pulse_end", 32'(pll_rst), 0);
    tick(4);
    chk("relock_ready_0", 32'(ready), 0);
    tick();
    chk("relock_ready_1", 32'(ready), 1);
    // Loss and force_relock in the same RUN cycle.
    pll_locked = 1'b0;
    tick(2);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk("both_loss2", 32'(loss_count), 2);
    chk("both_pll_rst", 32'(pll_rst), 1);
    chk("both_ready", 32'(ready), 0);
    pll_locked = 1'b1;
    tick(3);
    chk("both_single_pulse", 32'(pll_rst), 0);
    wait_ready("both_relock", 20);
    chk("both_loss_hold", 32'(loss_count), 2);
    // force_relock alone, then a 1-cycle lock glitch at stable count 2.
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk("force_pll_rst", 32'(pll_rst), 1);
    chk("force_no_loss", 32'(loss_count), 2);
    tick(4);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick(3);
    chk("qual_glitch_no_run", 32'(ready), 0);
    tick(3);
    chk("qual_fresh_3", 32'(ready), 0);
    tick();
    chk("qual_fresh_4", 32'(ready), 1);
    // 300 further losses saturate the counter.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick(3);
      if (i == 100) chk("loss_count_103", 32'(loss_count), 103);
      pll_locked = 1'b1;
      wait_ready("loss_loop_relock", 30);
    end
    chk("loss_sat", 32'(loss_count), 255);
    // Asynchronous reset during QUALIFY.
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    tick(5);
    chk("pre_areset_sys", 32'(sys_rst_n), 0);
    rst_n = 1'b0;
    #1;
    chk("areset_pll_rst", 32'(pll_rst), 1);
    chk("areset_sys", 32'(sys_rst_n), 0);
    chk("areset_ready", 32'(ready), 0);
    chk("areset_fault", 32'(fault), 0);
    chk("areset_retry", 32'(retry_count), 0);
    chk("areset_loss", 32'(loss_count), 0);
    // No lock at all: two timeouts then FAULT.
    pll_locked = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(18);
    chk("to1_pre_pll_rst", 32'(pll_rst), 0);
    chk("to1_pre_retry", 32'(retry_count), 0);
    tick();
    chk("to1_pll_rst", 32'(pll_rst), 1);
    chk("to1_retry", 32'(retry_count), 1);
    tick(2);
    chk("to1_pulse_e3", 32'(pll_rst), 1);
    tick();
    chk("to1_pulse_end", 32'(pll_rst), 0);
    tick(15);
    chk("to2_pre_fault", 32'(fault), 0);
    tick();
    chk("fault_set", 32'(fault), 1);
    chk("fault_retry", 32'(retry_count), 2);
    chk("fault_sys", 32'(sys_rst_n), 0);
    chk("fault_pll_rst", 32'(pll_rst), 0);
    tick(40);
    chk("fault_sticky", 32'(fault), 1);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk("fault_exit_retry", 32'(retry_count), 0);
    chk("fault_exit_pll_rst", 32'(pll_rst), 1);
    chk("fault_exit_fault", 32'(fault), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
